// File: rtl/sqw_sequencer.sv
// sqw_sequencer: square-wave timing sequencer with a double-buffered configuration.
// Software offers a configuration (high/low length, tick prescale, burst count)
// through a valid/ready handshake. The HIGH/LOW state machine drives wave_out.
// New settings are committed only at period boundaries, so the wave never glitches.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   cfg_valid/ready    configuration handshake (ready = pending slot free)
//   cfg_high/low       phase lengths in ticks (0 behaves as 1)
//   cfg_prescale       a tick lasts cfg_prescale+1 clocks
//   cfg_bursts         periods per run, 0 = continuous
//   start, stop        begin a run / stop gracefully at the end of the period
//   busy, wave_out     run active, square-wave output
//   period_done        one-clock pulse per completed period
//   burst_done         one-clock pulse when the burst count is exhausted
module sqw_sequencer #(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned PRE_WIDTH   = 8,
    parameter int unsigned BURST_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CNT_WIDTH-1:0]   cfg_high,
    input  logic [CNT_WIDTH-1:0]   cfg_low,
    input  logic [PRE_WIDTH-1:0]   cfg_prescale,
    input  logic [BURST_WIDTH-1:0] cfg_bursts,
    input  logic                   start,
    input  logic                   stop,
    output logic                   busy,
    output logic                   wave_out,
    output logic                   period_done,
    output logic                   burst_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    state_e                 state_q, state_d;

    logic [CNT_WIDTH-1:0]   act_high_q, act_high_d;
    logic [CNT_WIDTH-1:0]   act_low_q, act_low_d;
    logic [PRE_WIDTH-1:0]   act_prescale_q, act_prescale_d;
    logic [BURST_WIDTH-1:0] act_bursts_q, act_bursts_d;

    logic [CNT_WIDTH-1:0]   pend_high_q, pend_high_d;
    logic [CNT_WIDTH-1:0]   pend_low_q, pend_low_d;
    logic [PRE_WIDTH-1:0]   pend_prescale_q, pend_prescale_d;
    logic [BURST_WIDTH-1:0] pend_bursts_q, pend_bursts_d;
    logic                   pend_full_q, pend_full_d;
    logic                   have_cfg_q, have_cfg_d;

    logic [PRE_WIDTH-1:0]   pre_q, pre_d;
    logic [CNT_WIDTH-1:0]   phase_q, phase_d;
    logic [BURST_WIDTH-1:0] per_cnt_q, per_cnt_d;
    logic                   stop_req_q, stop_req_d;

    logic                   wave_q, wave_d;
    logic                   busy_q, busy_d;
    logic                   period_done_q, period_done_d;
    logic                   burst_done_q, burst_done_d;
    logic                   cfg_ready_q, cfg_ready_d;

    logic                   tick_c;
    logic                   xfer_c;
    logic [BURST_WIDTH-1:0] per_inc_c;

    // Phase length in ticks minus one; a programmed 0 behaves as 1.
    function automatic logic [CNT_WIDTH-1:0] len_m1(input logic [CNT_WIDTH-1:0] v);
        return (v == '0) ? '0 : v - CNT_WIDTH'(1);
    endfunction

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d         = state_q;
        act_high_d      = act_high_q;
        act_low_d       = act_low_q;
        act_prescale_d  = act_prescale_q;
        act_bursts_d    = act_bursts_q;
        pend_high_d     = pend_high_q;
        pend_low_d      = pend_low_q;
        pend_prescale_d = pend_prescale_q;
        pend_bursts_d   = pend_bursts_q;
        pend_full_d     = pend_full_q;
        have_cfg_d      = have_cfg_q;
        pre_d           = pre_q;
        phase_d         = phase_q;
        per_cnt_d       = per_cnt_q;
        stop_req_d      = stop_req_q;
        period_done_d   = 1'b0;
        burst_done_d    = 1'b0;

        tick_c    = (pre_q == act_prescale_q);
        xfer_c    = cfg_valid && !pend_full_q;
        per_inc_c = per_cnt_q + BURST_WIDTH'(1);

        // Accepting and committing are exclusive: one needs the slot empty, the other full.
        if (xfer_c) begin
            pend_high_d     = cfg_high;
            pend_low_d      = cfg_low;
            pend_prescale_d = cfg_prescale;
            pend_bursts_d   = cfg_bursts;
            pend_full_d     = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // Commit first so a start in the same cycle runs with the fresh config.
                if (pend_full_q) begin
                    act_high_d     = pend_high_q;
                    act_low_d      = pend_low_q;
                    act_prescale_d = pend_prescale_q;
                    act_bursts_d   = pend_bursts_q;
                    pend_full_d    = 1'b0;
                    have_cfg_d     = 1'b1;
                end
                if (start && (have_cfg_q || pend_full_q)) begin
                    state_d    = ST_HIGH;
                    pre_d      = '0;
                    phase_d    = len_m1(pend_full_q ? pend_high_q : act_high_q);
                    per_cnt_d  = '0;
                    stop_req_d = 1'b0;
                end
            end

            ST_HIGH: begin
                stop_req_d = stop_req_q || stop;
                pre_d      = tick_c ? '0 : pre_q + PRE_WIDTH'(1);
                if (tick_c) begin
                    if (phase_q == '0) begin
                        state_d = ST_LOW;
                        phase_d = len_m1(act_low_q);
                    end else begin
                        phase_d = phase_q - CNT_WIDTH'(1);
                    end
                end
            end

            ST_LOW: begin
                stop_req_d = stop_req_q || stop;
                pre_d      = tick_c ? '0 : pre_q + PRE_WIDTH'(1);
                if (tick_c) begin
                    if (phase_q != '0) begin
                        phase_d = phase_q - CNT_WIDTH'(1);
                    end else begin
                        period_done_d = 1'b1;
                        per_cnt_d     = per_inc_c;
                        if ((act_bursts_q != '0) && (per_inc_c == act_bursts_q)) begin
                            burst_done_d = 1'b1;
                            state_d      = ST_IDLE;
                        end else if (stop_req_q || stop) begin
                            state_d = ST_IDLE;
                        end else begin
                            // Period boundary: the only point where a running wave is retuned.
                            if (pend_full_q) begin
                                act_high_d     = pend_high_q;
                                act_low_d      = pend_low_q;
                                act_prescale_d = pend_prescale_q;
                                act_bursts_d   = pend_bursts_q;
                                pend_full_d    = 1'b0;
                                have_cfg_d     = 1'b1;
                            end
                            state_d = ST_HIGH;
                            phase_d = len_m1(pend_full_q ? pend_high_q : act_high_q);
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wave_d      = (state_d == ST_HIGH);
        busy_d      = (state_d != ST_IDLE);
        cfg_ready_d = !pend_full_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            act_high_q      <= '0;
            act_low_q       <= '0;
            act_prescale_q  <= '0;
            act_bursts_q    <= '0;
            pend_high_q     <= '0;
            pend_low_q      <= '0;
            pend_prescale_q <= '0;
            pend_bursts_q   <= '0;
            pend_full_q     <= 1'b0;
            have_cfg_q      <= 1'b0;
            pre_q           <= '0;
            phase_q         <= '0;
            per_cnt_q       <= '0;
            stop_req_q      <= 1'b0;
            wave_q          <= 1'b0;
            busy_q          <= 1'b0;
            period_done_q   <= 1'b0;
            burst_done_q    <= 1'b0;
            cfg_ready_q     <= 1'b1;
        end else begin
            state_q         <= state_d;
            act_high_q      <= act_high_d;
            act_low_q       <= act_low_d;
            act_prescale_q  <= act_prescale_d;
            act_bursts_q    <= act_bursts_d;
            pend_high_q     <= pend_high_d;
            pend_low_q      <= pend_low_d;
            pend_prescale_q <= pend_prescale_d;
            pend_bursts_q   <= pend_bursts_d;
            pend_full_q     <= pend_full_d;
            have_cfg_q      <= have_cfg_d;
            pre_q           <= pre_d;
            phase_q         <= phase_d;
            per_cnt_q       <= per_cnt_d;
            stop_req_q      <= stop_req_d;
            wave_q          <= wave_d;
            busy_q          <= busy_d;
            period_done_q   <= period_done_d;
            burst_done_q    <= burst_done_d;
            cfg_ready_q     <= cfg_ready_d;
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign busy        = busy_q;
    assign wave_out    = wave_q;
    assign period_done = period_done_q;
    assign burst_done  = burst_done_q;

endmodule

// File: tb/tb_sqw_sequencer.sv
// Self-checking bench for sqw_sequencer: a table of directed vectors, hand-written
// multi-cycle sequences, and random stimulus compared against a clock-counting model.
module tb_sqw_sequencer;

    localparam int unsigned CW = 16;
    localparam int unsigned PW = 8;
    localparam int unsigned BW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [CW-1:0] cfg_high = '0;
    logic [CW-1:0] cfg_low = '0;
    logic [PW-1:0] cfg_prescale = '0;
    logic [BW-1:0] cfg_bursts = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          busy, wave_out, period_done, burst_done;

    always #5 clk = ~clk;

    sqw_sequencer #(.CNT_WIDTH(CW), .PRE_WIDTH(PW), .BURST_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_high(cfg_high), .cfg_low(cfg_low), .cfg_prescale(cfg_prescale),
        .cfg_bursts(cfg_bursts), .start(start), .stop(stop), .busy(busy),
        .wave_out(wave_out), .period_done(period_done), .burst_done(burst_done)
    );

    int n_checks = 0;
    int n_err = 0;

    // Reference model: tracks remaining clocks per phase instead of ticks.
    int m_st;   // 0 idle, 1 high, 2 low
    int m_left, m_per;
    int ah, al, ap, ab, ph, pl, pp, pb;
    bit m_pf, m_have, m_sr;
    bit e_w, e_b, e_pd, e_bd, e_rdy;

    function automatic int plen(input int len, input int pre);
        return ((len == 0) ? 1 : len) * (pre + 1);
    endfunction

    task automatic m_commit();
        ah = ph; al = pl; ap = pp; ab = pb;
        m_pf = 1'b0; m_have = 1'b1;
    endtask

    task automatic model_step();
        bit old_pf;
        if (!rst_n) begin
            m_st = 0; m_left = 0; m_per = 0;
            ah = 0; al = 0; ap = 0; ab = 0; ph = 0; pl = 0; pp = 0; pb = 0;
            m_pf = 0; m_have = 0; m_sr = 0;
            e_w = 0; e_b = 0; e_pd = 0; e_bd = 0; e_rdy = 1;
            return;
        end
        old_pf = m_pf;
        e_pd = 0; e_bd = 0;
        if (cfg_valid && !old_pf) begin
            ph = int'(cfg_high); pl = int'(cfg_low);
            pp = int'(cfg_prescale); pb = int'(cfg_bursts);
            m_pf = 1'b1;
        end
        if (m_st == 0) begin
            if (old_pf) m_commit();
            if (start && m_have) begin
                m_st = 1; m_left = plen(ah, ap); m_per = 0; m_sr = 0;
            end
        end else if (m_st == 1) begin
            m_sr = m_sr | stop;
            m_left--;
            if (m_left == 0) begin
                m_st = 2; m_left = plen(al, ap);
            end
        end else begin
            m_sr = m_sr | stop;
            m_left--;
            if (m_left == 0) begin
                e_pd = 1;
                m_per = (m_per + 1) % (1 << BW);
                if (ab != 0 && m_per == ab) begin
                    e_bd = 1; m_st = 0;
                end else if (m_sr) begin
                    m_st = 0;
                end else begin
                    if (old_pf) m_commit();
                    m_st = 1; m_left = plen(ah, ap);
                end
            end
        end
        e_w = (m_st == 1);
        e_b = (m_st != 0);
        e_rdy = !m_pf;
    endtask

    // One clock: inputs already driven; sample 1 ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string pfx, input logic w, input logic b,
                             input logic pd, input logic bd, input logic rdy);
        chk({pfx, ".wave_out"},    wave_out,    w);
        chk({pfx, ".busy"},        busy,        b);
        chk({pfx, ".period_done"}, period_done, pd);
        chk({pfx, ".burst_done"},  burst_done,  bd);
        chk({pfx, ".cfg_ready"},   cfg_ready,   rdy);
    endtask

    task automatic set_cfg(input int h, input int l, input int p, input int b);
        cfg_high = CW'(h); cfg_low = CW'(l); cfg_prescale = PW'(p); cfg_bursts = BW'(b);
    endtask

    // Reset, then transfer a config and let it commit in IDLE.
    task automatic reset_and_load(input int h, input int l, input int p, input int b);
        start = 0; stop = 0; cfg_valid = 0;
        rst_n = 0; cyc(); rst_n = 1;
        set_cfg(h, l, p, b); cfg_valid = 1; cyc();
        cfg_valid = 0; cyc();
    endtask

    typedef struct {
        bit rst_n, cv;
        int h, l, p, b;
        bit st, sp;
        bit w, bz, pd, bd, rdy;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit cv, input int h, input int l,
                                input int p, input int b, input bit st, input bit sp,
                                input bit w, input bit bz, input bit pd, input bit bd,
                                input bit rdy);
        vec_t v;
        v.rst_n = r; v.cv = cv; v.h = h; v.l = l; v.p = p; v.b = b; v.st = st; v.sp = sp;
        v.w = w; v.bz = bz; v.pd = pd; v.bd = bd; v.rdy = rdy;
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        logic [1:10] t2_w, t2_b, t2_pd;
        logic [1:25] t3_w, t3_b, t3_pd, t3_r;
        logic [1:7]  t4_w, t4_b, t4_pd, t4_bd;

        // H=3 L=2 P=0 bursts=2 from reset: two periods then IDLE.
        tbl[0]  = mk(0,0,0,0,0,0, 0,0, 0,0,0,0,1);
        tbl[1]  = mk(1,1,3,2,0,2, 0,0, 0,0,0,0,0);
        tbl[2]  = mk(1,0,0,0,0,0, 0,0, 0,0,0,0,1);
        tbl[3]  = mk(1,0,0,0,0,0, 1,0, 1,1,0,0,1);
        tbl[4]  = mk(1,0,0,0,0,0, 0,0, 1,1,0,0,1);
        tbl[5]  = mk(1,0,0,0,0,0, 0,0, 1,1,0,0,1);
        tbl[6]  = mk(1,0,0,0,0,0, 0,0, 0,1,0,0,1);
        tbl[7]  = mk(1,0,0,0,0,0, 0,0, 0,1,0,0,1);
        tbl[8]  = mk(1,0,0,0,0,0, 0,0, 1,1,1,0,1);
        tbl[9]  = mk(1,0,0,0,0,0, 0,0, 1,1,0,0,1);
        tbl[10] = mk(1,0,0,0,0,0, 0,0, 1,1,0,0,1);
        tbl[11] = mk(1,0,0,0,0,0, 0,0, 0,1,0,0,1);
        tbl[12] = mk(1,0,0,0,0,0, 0,0, 0,1,0,0,1);
        tbl[13] = mk(1,0,0,0,0,0, 0,0, 0,0,1,1,1);
        tbl[14] = mk(1,0,0,0,0,0, 0,0, 0,0,0,0,1);

        for (int i = 0; i < 15; i++) begin
            rst_n = tbl[i].rst_n; cfg_valid = tbl[i].cv;
            set_cfg(tbl[i].h, tbl[i].l, tbl[i].p, tbl[i].b);
            start = tbl[i].st; stop = tbl[i].sp;
            cyc();
            check_all($sformatf("tbl%0d", i), tbl[i].w, tbl[i].bz, tbl[i].pd, tbl[i].bd, tbl[i].rdy);
        end

        // H=1 L=1 P=1 continuous, stop during the second HIGH.
        t2_w  = 10'b1100110000;
        t2_b  = 10'b1111111100;
        t2_pd = 10'b0000100010;
        reset_and_load(1, 1, 1, 0);
        for (int c = 1; c <= 10; c++) begin
            start = (c == 1); stop = (c == 6);
            cyc();
            check_all($sformatf("stop.c%0d", c), t2_w[c], t2_b[c], t2_pd[c], 1'b0, 1'b1);
        end
        stop = 0;

        // Retune 4/4 -> 2/6 mid-HIGH; a second offer is held off; stop in 3rd period.
        t3_w  = 25'b1111_0000_11_000000_11_000000_0;
        t3_b  = 25'b1111_1111_11_111111_11_111111_0;
        t3_pd = 25'b0000_0000_10_000000_10_000000_1;
        t3_r  = 25'b1000_0000_11_111111_11_111111_1;
        reset_and_load(4, 4, 0, 0);
        for (int c = 1; c <= 25; c++) begin
            start = (c == 1); stop = (c == 18);
            cfg_valid = (c == 2) || (c == 3);
            if (c == 2) set_cfg(2, 6, 0, 0);
            else if (c == 3) set_cfg(5, 5, 0, 0);
            cyc();
            check_all($sformatf("retune.c%0d", c), t3_w[c], t3_b[c], t3_pd[c], 1'b0, t3_r[c]);
        end
        stop = 0; cfg_valid = 0;

        // Zero lengths behave as 1/1, three bursts.
        t4_w  = 7'b1010100;
        t4_b  = 7'b1111110;
        t4_pd = 7'b0010101;
        t4_bd = 7'b0000001;
        reset_and_load(0, 0, 0, 3);
        for (int c = 1; c <= 7; c++) begin
            start = (c == 1);
            cyc();
            check_all($sformatf("zero.c%0d", c), t4_w[c], t4_b[c], t4_pd[c], t4_bd[c], 1'b1);
        end
        start = 0;

        // Start with no config is ignored; start+stop together in IDLE starts the run.
        rst_n = 0; cyc(); rst_n = 1;
        start = 1; cyc();
        check_all("nocfg", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        start = 0;
        set_cfg(1, 1, 0, 1); cfg_valid = 1; cyc();
        cfg_valid = 0; cyc();
        start = 1; stop = 1; cyc();
        check_all("ststop.c1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        start = 0; stop = 0; cyc();
        check_all("ststop.c2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc();
        check_all("ststop.c3", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Reset mid-LOW clears everything; later start is ignored.
        reset_and_load(2, 3, 0, 0);
        for (int c = 1; c <= 6; c++) begin
            start = (c == 1) || (c == 5);
            rst_n = (c != 4);
            cyc();
            check_all($sformatf("rstlow.c%0d", c), (c <= 2), (c <= 3), 1'b0, 1'b0, 1'b1);
        end
        rst_n = 1; start = 0;

        // Random stimulus against the model.
        rst_n = 0; cyc(); rst_n = 1;
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            set_cfg($urandom_range(0, 5), $urandom_range(0, 5),
                    $urandom_range(0, 3), $urandom_range(0, 4));
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            cyc();
            check_all($sformatf("rnd%0d", i), e_w, e_b, e_pd, e_bd, e_rdy);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
